// File: rtl/mem_io_pkg.sv
// Shared region-select type, I/O offsets and the I/O window decoder
// used by the memory/I-O map.
package mem_io_pkg;

  typedef enum logic [2:0] {
    SEL_IN   = 3'd0,
    SEL_OUT  = 3'd1,
    SEL_STAT = 3'd2,
    SEL_RAM  = 3'd3,
    SEL_NONE = 3'd4
  } sel_e;

  localparam logic [7:0] OFF_IN   = 8'h00;
  localparam logic [7:0] OFF_OUT  = 8'h40;
  localparam logic [7:0] OFF_STAT = 8'h80;

  // Classifies a word inside the 256-byte I/O window; word_off is offset[7:2].
  function automatic sel_e io_region(input logic [5:0] word_off,
                                     input int num_in, input int num_out);
    sel_e r;
    if ((word_off[5:4] == OFF_IN[7:6]) && (int'(word_off[3:0]) < num_in)) begin
      r = SEL_IN;
    end else if ((word_off[5:4] == OFF_OUT[7:6]) && (int'(word_off[3:0]) < num_out)) begin
      r = SEL_OUT;
    end else if (word_off == OFF_STAT[7:2]) begin
      r = SEL_STAT;
    end else begin
      r = SEL_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_io_ram.sv
// Single-port synchronous-read RAM; a same-cycle read and write of one word
// returns the old contents. Contents are never reset.
module mem_io_ram #(
  parameter int WIDTH         = 32,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [RAM_ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [2**RAM_ADDR_BITS];
  logic [WIDTH-1:0] rdata_q;

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_io_map.sv
// Memory-mapped RAM plus input/output port registers and a sticky
// new-data status word; reads complete one cycle after the request.
module mem_io_map
  import mem_io_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               RAM_ADDR_BITS = 8,
  parameter int               NUM_IN        = 2,
  parameter int               NUM_OUT       = 2,
  parameter logic [WIDTH-1:0] IO_BASE       = 32'h0000FF00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         address,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [NUM_IN-1:0]        inport_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [NUM_OUT*WIDTH-1:0] outport,
  output logic [NUM_IN-1:0]        in_status
);

  sel_e                     sel_s, sel_d, sel_q;
  logic [3:0]               idx_s;
  logic [WIDTH-1:0]         io_rd_s, io_rdata_d, io_rdata_q;
  logic [WIDTH-1:0]         ram_rdata_s;
  logic                     rd_valid_d, rd_valid_q;
  logic [NUM_IN*WIDTH-1:0]  inport_d, inport_q;
  logic [NUM_IN-1:0]        in_status_d, in_status_q;
  logic [NUM_OUT*WIDTH-1:0] outport_d, outport_q;

  // Address decode: I/O window by upper bits, everything else is RAM.
  always_comb begin
    idx_s = address[5:2];
    if (address[WIDTH-1:8] == IO_BASE[WIDTH-1:8]) begin
      sel_s = io_region(address[7:2], NUM_IN, NUM_OUT);
    end else begin
      sel_s = SEL_RAM;
    end
  end

  // Pre-edge I/O read value, captured at the request edge.
  always_comb begin
    io_rd_s = '0;
    case (sel_s)
      SEL_IN: begin
        for (int k = 0; k < NUM_IN; k++) begin
          io_rd_s = io_rd_s | ({WIDTH{idx_s == 4'(k)}} & inport_q[k*WIDTH +: WIDTH]);
        end
      end
      SEL_OUT: begin
        for (int k = 0; k < NUM_OUT; k++) begin
          io_rd_s = io_rd_s | ({WIDTH{idx_s == 4'(k)}} & outport_q[k*WIDTH +: WIDTH]);
        end
      end
      SEL_STAT: io_rd_s[NUM_IN-1:0] = in_status_q;
      default:  io_rd_s = '0;
    endcase
  end

  // Next-state for port registers, status flags and read pipeline.
  always_comb begin
    rd_valid_d = mem_read;
    if (mem_read) begin
      sel_d      = sel_s;
      io_rdata_d = io_rd_s;
    end else begin
      sel_d      = sel_q;
      io_rdata_d = io_rdata_q;
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      outport_d[k*WIDTH +: WIDTH] =
        (mem_write && (sel_s == SEL_OUT) && (idx_s == 4'(k))) ? wr_data
                                                              : outport_q[k*WIDTH +: WIDTH];
    end
    // A fresh strobe beats both the read-clear and the write-1-to-clear.
    for (int k = 0; k < NUM_IN; k++) begin
      inport_d[k*WIDTH +: WIDTH] = inport_en[k] ? in_data : inport_q[k*WIDTH +: WIDTH];
      in_status_d[k] = inport_en[k] |
                       (in_status_q[k] &
                        ~((mem_read && (sel_s == SEL_IN) && (idx_s == 4'(k))) ||
                          (mem_write && (sel_s == SEL_STAT) && wr_data[k])));
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= SEL_NONE;
      io_rdata_q  <= '0;
      rd_valid_q  <= 1'b0;
      inport_q    <= '0;
      in_status_q <= '0;
      outport_q   <= '0;
    end else begin
      sel_q       <= sel_d;
      io_rdata_q  <= io_rdata_d;
      rd_valid_q  <= rd_valid_d;
      inport_q    <= inport_d;
      in_status_q <= in_status_d;
      outport_q   <= outport_d;
    end
  end

  mem_io_ram #(
    .WIDTH         (WIDTH),
    .RAM_ADDR_BITS (RAM_ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (mem_write && (sel_s == SEL_RAM)),
    .re    (mem_read && (sel_s == SEL_RAM)),
    .addr  (address[RAM_ADDR_BITS+1:2]),
    .wdata (wr_data),
    .rdata (ram_rdata_s)
  );

  // sel_q only moves on a read, so rd_data holds between reads.
  assign rd_data   = (sel_q == SEL_RAM) ? ram_rdata_s : io_rdata_q;
  assign rd_valid  = rd_valid_q;
  assign outport   = outport_q;
  assign in_status = in_status_q;

endmodule
